// File: rtl/reg_sel_pkg.sv
//============================================================================
// Module : reg_sel_pkg
// Brief  : Shared constants and types for the register-address select pipe.
//          Macro REG_SEL_XZR_FLAG_EN adds the zero-register flag field.
// Rev    : 1.0
//============================================================================
`default_nettype none

package reg_sel_pkg;

    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sel_state_t;

    // Status bits carried with each entry. Data and select widths depend on
    // the top-level parameters, so the full entry struct is built there.
    typedef struct packed {
        logic err;
`ifdef REG_SEL_XZR_FLAG_EN
        logic is_xzr;
`endif
    } reg_sel_flags_t;

endpackage

`default_nettype wire

// File: rtl/reg_sel_skid.sv
//============================================================================
// Module : reg_sel_skid
// Brief  : Generic 2-entry valid/ready skid buffer with registered in_ready.
// Rev    : 1.0
//============================================================================
`default_nettype none

module reg_sel_skid
    import reg_sel_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    sel_state_t r_state;
    T           r_main;
    T           r_skid;
    logic       r_out_valid;
    logic       r_in_ready;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_main      <= in_data;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_main <= in_data;
                    end else if (w_push) begin
                        // Downstream stalled: park the new entry, stop accepting.
                        r_skid     <= in_data;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

endmodule

`default_nettype wire

// File: rtl/reg_addr_sel_pipe.sv
//============================================================================
// Module : reg_addr_sel_pipe
// Brief  : Selects one of NUM_IN register-address fields and forwards it
//          through a skid-buffered valid/ready stage. Macro
//          REG_SEL_XZR_FLAG_EN adds the out_is_xzr output.
// Rev    : 1.0
//============================================================================
`default_nettype none

module reg_addr_sel_pipe
    import reg_sel_pkg::*;
#(
    parameter  int WIDTH  = 5,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
`ifdef REG_SEL_XZR_FLAG_EN
    output logic                    out_is_xzr,
`endif
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        reg_sel_flags_t   flags;
    } entry_t;

    logic [WIDTH-1:0] w_cand [NUM_IN];
    logic [WIDTH-1:0] w_data;
    logic             w_err;
    entry_t           w_in;
    entry_t           w_out;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_cand
        assign w_cand[i] = in_data[i*WIDTH +: WIDTH];
    end

    // A power-of-two candidate count leaves no out-of-range select codes.
    if (NUM_IN == (1 << SEL_W)) begin : g_pow2
        assign w_err  = 1'b0;
        assign w_data = w_cand[sel];
    end else begin : g_npow2
        assign w_err  = (int'(sel) >= NUM_IN);
        assign w_data = w_err ? '0 : w_cand[sel];
    end

    always_comb begin
        w_in           = '0;
        w_in.data      = w_data;
        w_in.sel       = sel;
        w_in.flags.err = w_err;
`ifdef REG_SEL_XZR_FLAG_EN
        w_in.flags.is_xzr = !w_err && (w_data == WIDTH'(XZR_ADDR));
`endif
    end

    reg_sel_skid #(
        .T (entry_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (w_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = w_out.data;
    assign out_sel  = w_out.sel;
    assign out_err  = w_out.flags.err;
`ifdef REG_SEL_XZR_FLAG_EN
    assign out_is_xzr = w_out.flags.is_xzr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_addr_sel_pipe.sv
//============================================================================
// Module : tb_reg_addr_sel_pipe
// Brief  : Scoreboard bench for reg_addr_sel_pipe (NUM_IN=3, WIDTH=5).
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_reg_addr_sel_pipe;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int DW     = NUM_IN * WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DW-1:0]    in_data = '0;
    logic [SEL_W-1:0] sel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_err;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef REG_SEL_XZR_FLAG_EN
    logic             out_is_xzr;
`endif

    reg_addr_sel_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_err    (out_err),
`ifdef REG_SEL_XZR_FLAG_EN
        .out_is_xzr (out_is_xzr),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int sel;
        int err;
        int xzr;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the field by plain shifting, out-of-range -> 0 with err.
    function automatic exp_t model(input logic [DW-1:0] d, input int s);
        exp_t e;
        e.sel  = s;
        e.err  = (s >= NUM_IN) ? 1 : 0;
        e.data = e.err ? 0 : int'((d >> (s * WIDTH)) & ((1 << WIDTH) - 1));
        e.xzr  = (!e.err && e.data == 31) ? 1 : 0;
        return e;
    endfunction

    // Monitor: occupancy model, output stability, ordered scoreboard.
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [SEL_W-1:0] prev_sel;
    logic             prev_err;

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            exp_t e;
            check("out_valid_occupancy", int'(out_valid), (sbq.size() > 0) ? 1 : 0);
            check("in_ready_occupancy", int'(in_ready), (sbq.size() < 2) ? 1 : 0);
            if (stall_prev) begin
                check("stall_hold_data", int'(out_data), int'(prev_data));
                check("stall_hold_sel", int'(out_sel), int'(prev_sel));
                check("stall_hold_err", int'(out_err), int'(prev_err));
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_out++;
                check("out_data", int'(out_data), e.data);
                check("out_sel", int'(out_sel), e.sel);
                check("out_err", int'(out_err), e.err);
`ifdef REG_SEL_XZR_FLAG_EN
                check("out_is_xzr", int'(out_is_xzr), e.xzr);
`endif
            end
            if (in_valid && in_ready)
                sbq.push_back(model(in_data, int'(sel)));
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sel   = out_sel;
            prev_err   = out_err;
        end
    end

    function automatic logic [DW-1:0] pack(input int s, input int v);
        logic [DW-1:0] d;
        d = DW'($urandom);
        if (s < NUM_IN)
            d[s*WIDTH +: WIDTH] = WIDTH'(v);
        return d;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [DW-1:0] d, input int s);
        int cnt = 0;
        in_data  = d;
        sel      = SEL_W'(s);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", cnt);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_base;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_sel", int'(out_sel), 0);
        check("reset_out_err", int'(out_err), 0);
        @(posedge clk);
        #1;

        // First transfer: candidate 1 = 9, candidate 0 = 3
        out_ready = 1'b1;
        send({5'd0, 5'd9, 5'd3}, 1);
        cycles(2);

        // Stalled downstream: 4, 7 fill the buffer, 12 waits
        out_ready = 1'b0;
        send(pack(0, 4), 0);
        send(pack(0, 7), 0);
        fork
            send(pack(0, 12), 0);
            begin
                cycles(4);
                out_ready = 1'b1;
            end
        join
        cycles(3);

        // Out-of-range select then a valid one
        send(pack(0, 5), 3);
        send(pack(2, 17), 2);
        cycles(2);

        // Streaming: one in and one out every cycle
        out_base = n_out;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            sel      = SEL_W'($urandom_range(0, 3));
            in_data  = DW'($urandom);
            @(negedge clk);
            check("stream_in_ready", int'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cycles(3);
        check("stream_out_count", n_out - out_base, 20);

        // Reset while FULL
        out_ready = 1'b0;
        send(pack(1, 21), 1);
        send(pack(2, 22), 2);
        @(negedge clk);
        check("full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_out_valid", int'(out_valid), 0);
        check("post_reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycles(4);

        // Zero-register flag patterns
        send(pack(1, 31), 1);
        send(pack(0, 30), 0);
        cycles(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 4) != 0;
            sel       = SEL_W'($urandom_range(0, 3));
            in_data   = DW'($urandom);
            if ($urandom % 8 == 0)
                in_data = pack(int'(sel), 31);
            cycles(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles(5);
        check("drain_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
